// File: rtl/byte_data_memory.sv
// rtl/byte_data_memory.sv - byte-addressed data memory with self-clearing start-up
//
// Byte-addressed little-endian data memory of DEPTH bytes. It accepts byte, half
// and word loads and stores, one per cycle, and returns a registered response one
// cycle after each one is accepted. After every reset the memory is zeroed one
// 32-bit word per cycle before any request is accepted.
//
// Ports
//   clk           in   clock; all state changes on the rising edge
//   reset         in   synchronous reset, active low
//   req_valid     in   a request is present
//   req_ready     out  requests are accepted this cycle (READY state only)
//   req_write     in   1 = store, 0 = load
//   req_size      in   00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  in   1 = zero-extend loads, 0 = sign-extend loads
//   req_addr      in   byte address; only the low log2(DEPTH) bits select a byte
//   req_wdata     in   store data, right-aligned
//   rsp_valid     out  one-cycle pulse per accepted request
//   rsp_rdata     out  load data (0 for stores and for faulted requests)
//   rsp_err       out  the request faulted (misaligned or illegal size)

module byte_data_memory #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int WORDS = DEPTH / 4;
    localparam int CW    = AW - 2;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [7:0]    mem [DEPTH];

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;

    logic [AW-1:0] idx;
    logic          accept;
    logic          fault;
    logic          store_en;
    logic [3:0]    lane_en;
    logic [31:0]   raw_word;
    logic [31:0]   load_data;
    logic          clr_last;

    // Addresses wrap modulo DEPTH, so the upper address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW];

    assign idx      = req_addr[AW-1:0];
    assign accept   = req_valid && (state_q == ST_READY);
    assign clr_last = (clr_cnt_q == CW'(WORDS - 1));

    // --------------------------------------------------------------------
    // Request decode: alignment fault and byte-lane enables
    // --------------------------------------------------------------------
    always_comb begin
        fault   = 1'b1;
        lane_en = 4'b0000;
        case (req_size)
            SZ_BYTE: begin
                fault   = 1'b0;
                lane_en = 4'b0001;
            end
            SZ_HALF: begin
                fault   = req_addr[0];
                lane_en = 4'b0011;
            end
            SZ_WORD: begin
                fault   = |req_addr[1:0];
                lane_en = 4'b1111;
            end
            default: begin
                fault   = 1'b1;
                lane_en = 4'b0000;
            end
        endcase
    end

    assign store_en = accept && req_write && !fault;

    // --------------------------------------------------------------------
    // Load path: gather four little-endian bytes starting at idx, then
    // truncate and extend according to size. The AW-bit add wraps at DEPTH.
    // --------------------------------------------------------------------
    always_comb begin
        raw_word = '0;
        for (int i = 0; i < 4; i++) begin
            raw_word[8*i +: 8] = mem[idx + AW'(i)];
        end
    end

    always_comb begin
        load_data = '0;
        case (req_size)
            SZ_BYTE: load_data = {{24{~req_unsigned & raw_word[7]}},  raw_word[7:0]};
            SZ_HALF: load_data = {{16{~req_unsigned & raw_word[15]}}, raw_word[15:0]};
            SZ_WORD: load_data = raw_word;
            default: load_data = '0;
        endcase
    end

    // --------------------------------------------------------------------
    // Control and response next-state
    // --------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + CW'(1);
                if (clr_last) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    always_comb begin
        rsp_valid_d = accept;
        rsp_err_d   = accept && fault;
        rsp_rdata_d = '0;
        if (accept && !fault && !req_write) begin
            rsp_rdata_d = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // --------------------------------------------------------------------
    // Storage. No reset term on the array itself: the CLEAR sweep that
    // follows every reset is what guarantees all-zero contents at READY.
    // --------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state_q == ST_CLEAR) begin
                for (int i = 0; i < 4; i++) begin
                    mem[{clr_cnt_q, 2'(i)}] <= 8'h00;
                end
            end else if (store_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (lane_en[i]) begin
                        mem[idx + AW'(i)] <= req_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // Outputs are masked while reset is held so that a response already
    // registered for the cycle in which reset arrives is never presented.
    assign req_ready = (state_q == ST_READY) && reset;
    assign rsp_valid = rsp_valid_q && reset;
    assign rsp_err   = rsp_err_q && reset;
    assign rsp_rdata = reset ? rsp_rdata_q : 32'h0000_0000;

endmodule
